// File: rtl/tug_referee_pkg.sv
// rtl/tug_referee_pkg.sv - shared types, defaults and helpers for the tug-of-war referee
package tug_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, WIN, DONE} state_t;

  localparam int DEF_LIGHTS   = 9;
  localparam int DEF_SCORE_W  = 3;
  localparam int DEF_WIN_HOLD = 4;
  localparam int MAX_LIGHTS   = 64;

  // Callers truncate the result to their own LIGHTS width.
  function automatic logic [MAX_LIGHTS-1:0] centre_onehot(input int lights);
    logic [MAX_LIGHTS-1:0] v;
    v = '0;
    v[(lights-1)/2] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tug_referee_if.sv
// rtl/tug_referee_if.sv - player/referee signal bundle for the tug-of-war board
interface tug_referee_if #(
  parameter int LIGHTS  = 9,
  parameter int SCORE_W = 3
);
  logic               start;
  logic               pressL;
  logic               pressR;
  logic [LIGHTS-1:0]  lights;
  logic               winL;
  logic               winR;
  logic [SCORE_W-1:0] scoreL;
  logic [SCORE_W-1:0] scoreR;
  logic               playing;

  modport master (
    output start, pressL, pressR,
    input  lights, winL, winR, scoreL, scoreR, playing
  );

  modport slave (
    input  start, pressL, pressR,
    output lights, winL, winR, scoreL, scoreR, playing
  );
endinterface

// File: rtl/tug_referee_hold_timer.sv
// rtl/tug_referee_hold_timer.sv - loadable down-counter timing the winner display
module hold_timer #(
  parameter int W = 3
) (
  input  logic         Clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Parks at zero once the display time has run out.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/tug_referee.sv
// rtl/tug_referee.sv - tug-of-war game FSM, rope position and scoring
// Optional TUG_TIE_ALTERNATE_EN: simultaneous presses are granted round-robin instead of cancelling.
module tug_referee
  import tug_pkg::*;
#(
  parameter int LIGHTS   = DEF_LIGHTS,
  parameter int SCORE_W  = DEF_SCORE_W,
  parameter int WIN_HOLD = DEF_WIN_HOLD
) (
  input logic          Clock,
  input logic          reset,
  tug_referee_if.slave bus
);

  localparam int                 HW        = $clog2(WIN_HOLD + 1);
  localparam logic [LIGHTS-1:0]  CENTRE    = LIGHTS'(centre_onehot(LIGHTS));
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             state;
  logic [LIGHTS-1:0]  lights_q;
  logic [SCORE_W-1:0] score_l_q, score_r_q;
  logic [SCORE_W-1:0] next_l, next_r;
  logic               win_l_q, win_r_q, playing_q;
  logic               move_l, move_r;
  logic               score_l, score_r;
  logic               accept_start;
  logic               expire;

  hold_timer #(.W(HW)) u_hold (
    .Clock  (Clock),
    .reset  (reset),
    .load   (score_l | score_r),
    .value  (HW'(WIN_HOLD)),
    .expire (expire)
  );

  assign accept_start = bus.start && (state == IDLE || state == DONE);

`ifdef TUG_TIE_ALTERNATE_EN
  logic tie;
  logic prio_r;

  assign tie = bus.pressL & bus.pressR;

  always_ff @(posedge Clock) begin
    if (!reset || accept_start) begin
      prio_r <= 1'b0;
    end else if (state == PLAY && tie) begin
      prio_r <= ~prio_r;
    end
  end

  always_comb begin
    move_l = bus.pressL & ~bus.pressR;
    move_r = bus.pressR & ~bus.pressL;
    if (tie) begin
      move_l = ~prio_r;
      move_r = prio_r;
    end
  end
`else
  always_comb begin
    move_l = bus.pressL & ~bus.pressR;
    move_r = bus.pressR & ~bus.pressL;
  end
`endif

  // A move into the edge the rope already sits on is a point, not a shift.
  assign score_l = (state == PLAY) && move_l && lights_q[LIGHTS-1];
  assign score_r = (state == PLAY) && move_r && lights_q[0];
  assign next_l  = score_l_q + 1'b1;
  assign next_r  = score_r_q + 1'b1;

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state     <= IDLE;
      lights_q  <= CENTRE;
      score_l_q <= '0;
      score_r_q <= '0;
      win_l_q   <= 1'b0;
      win_r_q   <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= PLAY;
            lights_q  <= CENTRE;
            score_l_q <= '0;
            score_r_q <= '0;
            win_l_q   <= 1'b0;
            win_r_q   <= 1'b0;
            playing_q <= 1'b1;
          end
        end
        PLAY: begin
          if (score_l) begin
            score_l_q <= next_l;
            win_l_q   <= 1'b1;
            playing_q <= 1'b0;
            state     <= (next_l == SCORE_MAX) ? DONE : WIN;
          end else if (score_r) begin
            score_r_q <= next_r;
            win_r_q   <= 1'b1;
            playing_q <= 1'b0;
            state     <= (next_r == SCORE_MAX) ? DONE : WIN;
          end else if (move_l) begin
            lights_q <= lights_q << 1;
          end else if (move_r) begin
            lights_q <= lights_q >> 1;
          end
        end
        WIN: begin
          if (expire) begin
            state     <= PLAY;
            lights_q  <= CENTRE;
            win_l_q   <= 1'b0;
            win_r_q   <= 1'b0;
            playing_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.lights  = lights_q;
  assign bus.winL    = win_l_q;
  assign bus.winR    = win_r_q;
  assign bus.scoreL  = score_l_q;
  assign bus.scoreR  = score_r_q;
  assign bus.playing = playing_q;

endmodule

// File: tb/tb_tug_referee.sv
// tb/tb_tug_referee.sv - scoreboard bench for tug_referee with hand-derived vectors
module tb_tug_referee;

  typedef struct {
    logic [8:0] lights;
    logic       wl;
    logic       wr;
    logic [2:0] sl;
    logic [2:0] sr;
    logic       pg;
    string      nm;
  } exp_t;

  logic Clock = 1'b0;
  logic reset = 1'b0;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done_drive = 1'b0;

  tug_referee_if #(.LIGHTS(9), .SCORE_W(3)) bus ();

  tug_referee #(.LIGHTS(9), .SCORE_W(3), .WIN_HOLD(4)) dut (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic step(input logic rn, input logic st, input logic pl, input logic pr,
                      input int li, input logic wl, input logic wr,
                      input int sl, input int sr, input logic pg, input string nm);
    exp_t       e;
    logic [8:0] one;
    @(negedge Clock);
    reset      = rn;
    bus.start  = st;
    bus.pressL = pl;
    bus.pressR = pr;
    @(posedge Clock);
    #1;
    one      = 9'd1;
    e.lights = one << li;
    e.wl     = wl;
    e.wr     = wr;
    e.sl     = 3'(sl);
    e.sr     = 3'(sr);
    e.pg     = pg;
    e.nm     = nm;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    logic [16:0] act, req;
    forever begin
      @(negedge Clock);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {bus.lights, bus.winL, bus.winR, bus.scoreL, bus.scoreR, bus.playing};
        req = {e.lights, e.wl, e.wr, e.sl, e.sr, e.pg};
        checks++;
        if (act !== req) begin
          errors++;
          $display("FAIL %s: got lights=%b wl=%b wr=%b sl=%0d sr=%0d pg=%b, expected lights=%b wl=%b wr=%b sl=%0d sr=%0d pg=%b",
                   e.nm, bus.lights, bus.winL, bus.winR, bus.scoreL, bus.scoreR, bus.playing,
                   e.lights, e.wl, e.wr, e.sl, e.sr, e.pg);
        end
      end
    end
  end

  initial begin
    bus.start  = 1'b0;
    bus.pressL = 1'b0;
    bus.pressR = 1'b0;

    step(0, 0, 0, 0, 4, 0, 0, 0, 0, 0, "reset_0");
    step(0, 0, 0, 0, 4, 0, 0, 0, 0, 0, "reset_1");
    step(1, 0, 1, 0, 4, 0, 0, 0, 0, 0, "idle_press_l");
    step(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, "idle_press_r");
    step(1, 1, 0, 0, 4, 0, 0, 0, 0, 1, "start");
    step(1, 1, 0, 0, 4, 0, 0, 0, 0, 1, "start_in_play");

`ifdef TUG_TIE_ALTERNATE_EN
    step(1, 0, 1, 1, 5, 0, 0, 0, 0, 1, "tie_1");
    step(1, 0, 1, 1, 4, 0, 0, 0, 0, 1, "tie_2");
    step(1, 0, 1, 1, 5, 0, 0, 0, 0, 1, "tie_3");
    step(1, 0, 0, 1, 4, 0, 0, 0, 0, 1, "tie_recentre");
`else
    step(1, 0, 1, 1, 4, 0, 0, 0, 0, 1, "tie_1");
    step(1, 0, 1, 1, 4, 0, 0, 0, 0, 1, "tie_2");
    step(1, 0, 1, 1, 4, 0, 0, 0, 0, 1, "tie_3");
`endif

    for (int k = 1; k <= 4; k++) step(1, 0, 1, 0, 4 + k, 0, 0, 0, 0, 1, "left_move");
    step(1, 0, 1, 0, 8, 1, 0, 1, 0, 0, "left_point");
    step(1, 0, 0, 1, 8, 1, 0, 1, 0, 0, "win_press_r");
    step(1, 1, 0, 0, 8, 1, 0, 1, 0, 0, "win_start");
    step(1, 0, 1, 1, 8, 1, 0, 1, 0, 0, "win_press_both");
    step(1, 0, 1, 0, 4, 0, 0, 1, 0, 1, "win_expire");

    for (int p = 1; p <= 7; p++) begin
      for (int k = 1; k <= 4; k++) step(1, 0, 0, 1, 4 - k, 0, 0, 1, p - 1, 1, "right_move");
      if (p < 7) begin
        step(1, 0, 0, 1, 0, 0, 1, 1, p, 0, "right_point");
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 1, 1, p, 0, "right_hold");
        step(1, 0, 0, 0, 4, 0, 0, 1, p, 1, "right_resume");
      end else begin
        step(1, 0, 0, 1, 0, 0, 1, 1, 7, 0, "right_match");
      end
    end
    step(1, 0, 1, 0, 0, 0, 1, 1, 7, 0, "done_press_l");
    step(1, 0, 0, 1, 0, 0, 1, 1, 7, 0, "done_press_r");
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0, 0, 0, 1, 1, 7, 0, "done_hold");
    step(1, 1, 0, 0, 4, 0, 0, 0, 0, 1, "done_start");

    for (int k = 1; k <= 4; k++) step(1, 0, 1, 0, 4 + k, 0, 0, 0, 0, 1, "left_move_2");
    step(1, 0, 1, 0, 8, 1, 0, 1, 0, 0, "left_point_2");
    step(1, 0, 0, 0, 8, 1, 0, 1, 0, 0, "win_hold_2");
    step(0, 0, 0, 0, 4, 0, 0, 0, 0, 0, "reset_in_win");
    step(1, 0, 1, 0, 4, 0, 0, 0, 0, 0, "idle_after_reset");
    step(1, 0, 0, 0, 4, 0, 0, 0, 0, 0, "idle_quiet");

    done_drive = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clock);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
